// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF sampler: default sizes, FSM state type, counter width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package puf_pkg;

  localparam int PUF_SIZE_DEF   = 8;
  localparam int PUF_VOTES_DEF  = 7;
  localparam int PUF_SETTLE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RELAX = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } sampler_state_t;

  // Bits needed to count 0..votes inclusive
  function automatic int vote_width(input int votes);
    return $clog2(votes + 1);
  endfunction

endpackage

// File: rtl/puf_vote_counter.sv
// Per-bit vote counter: counts evaluations that returned 1; flags majority (and unanimity with PUF_STABILITY_MASK_EN).
// Latency: count updates on the edge after inc; majority/unanimous are combinational from the count.
// Backpressure: none; the caller bounds increments to VOTES so the counter cannot overflow.
module puf_vote_counter
  import puf_pkg::*;
#(
  parameter int VOTES = PUF_VOTES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic majority
`ifdef PUF_STABILITY_MASK_EN
  ,
  output logic unanimous
`endif
);

  localparam int CW = vote_width(VOTES);

  logic [CW-1:0] count;

  // Count ones seen on this bit; cleared when a new key request is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign majority = (count > CW'(VOTES / 2));

`ifdef PUF_STABILITY_MASK_EN
  assign unanimous = (count == '0) || (count == CW'(VOTES));
`endif

endmodule

// File: rtl/puf_arbiter_sampler.sv
// Arbiter-PUF sequencer: runs VOTES relax/evaluate rounds per challenge and majority-votes each response bit into a key.
// Latency: key_valid rises 2*SETTLE*VOTES+1 cycles after the accepted start (57 with defaults).
// Backpressure: key/key_valid (and unstable under PUF_STABILITY_MASK_EN) hold in DONE until key_ready; start ignored while busy.
module puf_arbiter_sampler
  import puf_pkg::*;
#(
  parameter int SIZE   = PUF_SIZE_DEF,
  parameter int VOTES  = PUF_VOTES_DEF,
  parameter int SETTLE = PUF_SETTLE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] challenge_in,
  output logic            busy,
  output logic            enable,
  output logic [SIZE-1:0] challenge,
  input  logic [SIZE-1:0] response,
  output logic [SIZE-1:0] key,
  output logic            key_valid,
  input  logic            key_ready
`ifdef PUF_STABILITY_MASK_EN
  ,
  output logic [SIZE-1:0] unstable
`endif
);

  localparam int VW = vote_width(VOTES);
  localparam int PW = $clog2(SETTLE + 1);

  sampler_state_t state, nxt;
  logic [PW-1:0]  phase_cnt;
  logic [VW-1:0]  vote_idx;
  logic           phase_last;
  logic           clr_votes;
  logic           take_vote;
  logic           load_key;
  logic           release_key;
  logic [SIZE-1:0] maj;
`ifdef PUF_STABILITY_MASK_EN
  logic [SIZE-1:0] unan;
`endif

  assign phase_last = (phase_cnt == '0);
  assign busy       = (state != IDLE);
  assign enable     = (state == EVAL);

  // Next-state and per-cycle strobes; the first DONE cycle registers the vote result
  always_comb begin
    nxt         = state;
    clr_votes   = 1'b0;
    take_vote   = 1'b0;
    load_key    = 1'b0;
    release_key = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nxt       = RELAX;
          clr_votes = 1'b1;
        end
      end
      RELAX: begin
        if (phase_last) nxt = EVAL;
      end
      EVAL: begin
        if (phase_last) begin
          take_vote = 1'b1;
          nxt       = (vote_idx == VW'(VOTES - 1)) ? DONE : RELAX;
        end
      end
      DONE: begin
        if (!key_valid) begin
          load_key = 1'b1;
        end else if (key_ready) begin
          release_key = 1'b1;
          nxt         = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Phase timer: reloads on every state change, counts down to the last cycle of the phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_cnt <= '0;
    end else if (state != nxt) begin
      phase_cnt <= PW'(SETTLE - 1);
    end else if (!phase_last) begin
      phase_cnt <= phase_cnt - PW'(1);
    end
  end

  // Vote index: one step per completed evaluation, cleared on accepted start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vote_idx <= '0;
    end else if (clr_votes) begin
      vote_idx <= '0;
    end else if (take_vote) begin
      vote_idx <= vote_idx + VW'(1);
    end
  end

  // Challenge is captured once and held for the whole sequence
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      challenge <= '0;
    end else if (state == IDLE && start) begin
      challenge <= challenge_in;
    end
  end

  // Key output register: loaded on the first DONE cycle, valid dropped on handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key       <= '0;
      key_valid <= 1'b0;
    end else if (load_key) begin
      key       <= maj;
      key_valid <= 1'b1;
    end else if (release_key) begin
      key_valid <= 1'b0;
    end
  end

`ifdef PUF_STABILITY_MASK_EN
  // Stability mask follows key timing but clears when the key is consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      unstable <= '0;
    end else if (load_key) begin
      unstable <= ~unan;
    end else if (release_key) begin
      unstable <= '0;
    end
  end
`endif

  for (genvar i = 0; i < SIZE; i++) begin : g_vote
    puf_vote_counter #(
      .VOTES(VOTES)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr_votes),
      .inc      (take_vote & response[i]),
      .majority (maj[i])
`ifdef PUF_STABILITY_MASK_EN
      ,
      .unanimous(unan[i])
`endif
    );
  end

endmodule

// File: tb/tb_puf_arbiter_sampler.sv
// Scoreboard bench for puf_arbiter_sampler: default instance plus a VOTES=1/SETTLE=1 instance.
// Latency: expected key latency is 2*SETTLE*VOTES+1 from the accepted start.
// Backpressure: exercised by holding key_ready low after key_valid.
module tb_puf_arbiter_sampler;

  localparam int VOTES  = 7;
  localparam int SETTLE = 4;
  localparam int LAT    = 2 * SETTLE * VOTES + 1;
  localparam int LAT1   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [7:0] challenge_in;
  logic       busy, enable, key_valid, key_ready;
  logic [7:0] challenge, key;
  logic [7:0] response = 8'h00;
  logic [7:0] unstable;

  logic       start1, busy1, en1, kv1;
  logic       kr1 = 1'b1;
  logic [7:0] cin1, chal1, resp1, key1, unst1;

  puf_arbiter_sampler u0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .challenge_in(challenge_in),
    .busy        (busy),
    .enable      (enable),
    .challenge   (challenge),
    .response    (response),
    .key         (key),
    .key_valid   (key_valid),
    .key_ready   (key_ready)
`ifdef PUF_STABILITY_MASK_EN
    ,
    .unstable    (unstable)
`endif
  );

  puf_arbiter_sampler #(.SIZE(8), .VOTES(1), .SETTLE(1)) u1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start1),
    .challenge_in(cin1),
    .busy        (busy1),
    .enable      (en1),
    .challenge   (chal1),
    .response    (resp1),
    .key         (key1),
    .key_valid   (kv1),
    .key_ready   (kr1)
`ifdef PUF_STABILITY_MASK_EN
    ,
    .unstable    (unst1)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] key;
    logic [7:0] unst;
    logic [7:0] chal;
    int         start;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [7:0] tab [VOTES];
  logic [7:0] exp_chal = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Arbiter array model: per-vote value while Enable is high, inverted value while relaxing
  logic pm_en = 1'b0, pm_busy = 1'b0;
  int   vidx = 0;
  always @(posedge clk) begin
    #1;
    if (busy && !pm_busy) vidx = 0;
    if (enable && !pm_en) begin
      response = tab[vidx % VOTES];
      vidx++;
    end else if (!enable && pm_en) begin
      response = ~response;
    end
    pm_en   = enable;
    pm_busy = busy;
  end

  // Monitor for the default instance: challenge hold, enable pulse shape, key scoreboard
  logic p_kv = 1'b0, p_en = 1'b0, p_busy = 1'b0;
  int   rises = 0, hlen = 0;
  always @(negedge clk) begin
    if (busy && !p_busy) begin
      rises = 0;
      hlen  = 0;
    end
    if (busy) chk("challenge_hold", challenge, exp_chal);
    if (enable && !p_en) rises++;
    if (enable) hlen++;
    if (!enable && p_en && busy) chk("enable_width", hlen, SETTLE);
    if (!enable) hlen = 0;
    if (key_valid && !p_kv) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_key actual=%0h required=none", key);
      end else begin
        e0 = q0.pop_front();
        chk("key", key, e0.key);
        chk("key_latency", cyc - e0.start, e0.lat);
        chk("enable_pulses", rises, VOTES);
        chk("enable_in_done", enable, 1'b0);
        chk("challenge_at_key", challenge, e0.chal);
`ifdef PUF_STABILITY_MASK_EN
        chk("unstable", unstable, e0.unst);
`endif
      end
    end
    p_kv   = key_valid;
    p_en   = enable;
    p_busy = busy;
  end

  // Monitor for the single-vote instance
  logic p_kv1 = 1'b0;
  always @(negedge clk) begin
    if (kv1 && !p_kv1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_key1 actual=%0h required=none", key1);
      end else begin
        e1 = q1.pop_front();
        chk("key1", key1, e1.key);
        chk("key1_latency", cyc - e1.start, e1.lat);
        chk("challenge1", chal1, e1.chal);
`ifdef PUF_STABILITY_MASK_EN
        chk("unstable1", unst1, e1.unst);
`endif
      end
    end
    p_kv1 = kv1;
  end

  task automatic issue(input logic [7:0] ch, input logic [7:0] k, input logic [7:0] u, input logic push);
    exp_t e;
    @(negedge clk);
    challenge_in = ch;
    exp_chal     = ch;
    start        = 1'b1;
    e.key   = k;
    e.unst  = u;
    e.chal  = ch;
    e.start = cyc + 1;
    e.lat   = LAT;
    if (push) q0.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue1(input logic [7:0] ch, input logic [7:0] r);
    exp_t e;
    @(negedge clk);
    cin1   = ch;
    resp1  = r;
    start1 = 1'b1;
    e.key   = r;
    e.unst  = 8'h00;
    e.chal  = ch;
    e.start = cyc + 1;
    e.lat   = LAT1;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_kv(input string nm, input int budget);
    int n = 0;
    while (!key_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!key_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_key_valid required=key_valid_within_%0d", nm, budget);
    end
  endtask

  task automatic wait_kv1(input int budget);
    int n = 0;
    while (!kv1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!kv1) begin
      checks++;
      errors++;
      $display("FAIL kv1_timeout actual=no_key_valid required=key_valid_within_%0d", budget);
    end
  endtask

  task automatic set_tab(input logic [7:0] v);
    for (int i = 0; i < VOTES; i++) tab[i] = v;
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    start        = 1'b1;
    key_ready    = 1'b1;
    challenge_in = 8'h77;
    start1       = 1'b1;
    cin1         = 8'h55;
    resp1        = 8'h00;
    set_tab(8'h00);

    // Reset held with start asserted: nothing may start
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_enable", enable, 1'b0);
      chk("rst_challenge", challenge, 8'h00);
      chk("rst_key", key, 8'h00);
      chk("rst_key_valid", key_valid, 1'b0);
      chk("rst_busy1", busy1, 1'b0);
`ifdef PUF_STABILITY_MASK_EN
      chk("rst_unstable", unstable, 8'h00);
`endif
    end
    rst_n  = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;

    // Constant response
    set_tab(8'hA5);
    issue(8'h3C, 8'hA5, 8'h00, 1'b1);
    wait_kv("const", 200);
    @(negedge clk);
    chk("const_release_kv", key_valid, 1'b0);
    chk("const_release_busy", busy, 1'b0);

    // Noisy bits: bit0 set in 4 of 7 votes, bit1 set in 3 of 7
    tab[0] = 8'h01; tab[1] = 8'h01; tab[2] = 8'h01; tab[3] = 8'h01;
    tab[4] = 8'h02; tab[5] = 8'h02; tab[6] = 8'h02;
    issue(8'hC3, 8'h01, 8'h03, 1'b1);
    wait_kv("noisy", 200);
    @(negedge clk);

    // Backpressure with start pulses while busy
    key_ready = 1'b0;
    set_tab(8'h96);
    issue(8'hE1, 8'h96, 8'h00, 1'b1);
    wait_kv("bp", 200);
    for (int i = 0; i < 10; i++) begin
      start        = i[0];
      challenge_in = 8'h0F;
      @(negedge clk);
      chk("bp_key", key, 8'h96);
      chk("bp_key_valid", key_valid, 1'b1);
      chk("bp_busy", busy, 1'b1);
    end
    start     = 1'b0;
    key_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_kv", key_valid, 1'b0);
    chk("bp_release_busy", busy, 1'b0);
    @(negedge clk);
    chk("bp_no_restart", busy, 1'b0);

    // Reset in the middle of the third evaluation
    set_tab(8'h33);
    issue(8'h5A, 8'h00, 8'h00, 1'b0);
    n = 0;
    while (!(rises >= 3 && hlen >= 2) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!(rises >= 3 && hlen >= 2)) begin
      checks++;
      errors++;
      $display("FAIL abort_point_timeout actual=rises_%0d required=rises_3", rises);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_enable", enable, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_key_valid", key_valid, 1'b0);
    chk("abort_challenge", challenge, 8'h00);
    rst_n = 1'b1;
    set_tab(8'hFF);
    issue(8'hC0, 8'hFF, 8'h00, 1'b1);
    wait_kv("after_abort", 200);
    @(negedge clk);

    // Single vote, single-cycle phases
    issue1(8'hAA, 8'h96);
    wait_kv1(20);
    @(negedge clk);
    chk("sweep_release", kv1, 1'b0);
    issue1(8'h17, 8'h41);
    wait_kv1(20);
    @(negedge clk);

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
